// File: rtl/fp_add_sub_seq.sv
// Multi-cycle IEEE-754 single-precision add/subtract. Truncating alignment,
// no rounding; inf/NaN operands and exponent overflow flag an exception.
module fp_add_sub_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        add_sub_signal,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] res,
  output logic        exception
);

  localparam int unsigned EW = 8;
  localparam int unsigned MW = 23;
  localparam int unsigned SW = 25;
  localparam int unsigned CW = 5;

  typedef enum logic [2:0] {IDLE, LOAD, ALIGN, COMPUTE, NORM, DONE} state_t;

  state_t state, state_nx;

  logic [31:0]   op_a, op_b;
  logic          op_sub;
  logic [SW-1:0] sig_x, sig_y;
  logic [EW-1:0] exp_w;
  logic          sign_r, eff_sub, exc_r;
  logic [CW-1:0] cnt;

  logic [31:0]   x_c, y_c, big_c;
  logic [30:0]   small_c;
  logic          x_ge_y_c, inf_nan_c, norm_exit_c;
  logic [EW-1:0] d_c;
  logic [CW-1:0] shift_c;

  // Operand ordering: larger magnitude first, ties keep a in front
  always_comb begin
    x_c         = op_a;
    y_c         = {op_b[31] ^ op_sub, op_b[30:0]};
    x_ge_y_c    = (x_c[30:0] >= y_c[30:0]);
    big_c       = x_ge_y_c ? x_c : y_c;
    small_c     = x_ge_y_c ? y_c[30:0] : x_c[30:0];
    d_c         = big_c[30:MW] - small_c[30:MW];
    shift_c     = (d_c > 8'd25) ? CW'(25) : d_c[CW-1:0];
    inf_nan_c   = (op_a[30:MW] == 8'hFF) || (op_b[30:MW] == 8'hFF);
    norm_exit_c = sig_x[SW-1] || (sig_x == '0) || sig_x[MW] || (exp_w <= 8'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD: begin
        if (inf_nan_c)            state_nx = DONE;
        else if (shift_c == '0)   state_nx = COMPUTE;
        else                      state_nx = ALIGN;
      end
      ALIGN:   if (cnt == CW'(1)) state_nx = COMPUTE;
      COMPUTE: state_nx = NORM;
      NORM:    if (norm_exit_c)   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Working datapath, advanced by the current state
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      op_sub  <= 1'b0;
      sig_x   <= '0;
      sig_y   <= '0;
      exp_w   <= '0;
      sign_r  <= 1'b0;
      eff_sub <= 1'b0;
      exc_r   <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a   <= a;
            op_b   <= b;
            op_sub <= add_sub_signal;
          end
        end
        LOAD: begin
          sig_x   <= {1'b0, |big_c[30:MW], big_c[MW-1:0]};
          sig_y   <= {1'b0, |small_c[30:MW], small_c[MW-1:0]};
          exp_w   <= big_c[30:MW];
          sign_r  <= big_c[31];
          eff_sub <= x_c[31] ^ y_c[31];
          cnt     <= shift_c;
          exc_r   <= inf_nan_c;
        end
        ALIGN: begin
          sig_y <= sig_y >> 1;
          cnt   <= cnt - CW'(1);
        end
        COMPUTE: sig_x <= eff_sub ? (sig_x - sig_y) : (sig_x + sig_y);
        NORM: begin
          if (sig_x[SW-1]) begin
            sig_x <= sig_x >> 1;
            exp_w <= exp_w + 8'd1;
            if (exp_w == 8'hFE) exc_r <= 1'b1;
          end else if (sig_x == '0) begin
            sign_r <= 1'b0;
            exp_w  <= '0;
          end else if (sig_x[MW] || (exp_w <= 8'd1)) begin
            if (!sig_x[MW]) exp_w <= '0;
          end else begin
            sig_x <= sig_x << 1;
            exp_w <= exp_w - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs; res/exception update only alongside done
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      res       <= '0;
      exception <= 1'b0;
    end else begin
      busy <= (state_nx != IDLE);
      done <= (state == DONE);
      if (state == DONE) begin
        res       <= exc_r ? {sign_r, 8'hFF, 23'd0} : {sign_r, exp_w, sig_x[MW-1:0]};
        exception <= exc_r;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_sub_seq.sv
// Directed bench for fp_add_sub_seq: a spec-level arithmetic model predicts
// result, exception flag and latency; one process checks outputs every cycle.
module tb_fp_add_sub_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        add_sub_signal;
  logic [31:0] a, b;
  logic        busy, done, exception;
  logic [31:0] res;

  int          checks;
  int          errors;
  int          cyc;
  int          start_cyc;
  int          exp_lat;
  logic [31:0] exp_res;
  logic        exp_exc;
  logic        pending;
  logic        clear_req;
  logic        chk_on;
  logic [31:0] held_res;
  logic        held_exc;
  int          el;
  logic        exp_done, exp_busy;

  fp_add_sub_seq dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .add_sub_signal (add_sub_signal),
    .a              (a),
    .b              (b),
    .busy           (busy),
    .done           (done),
    .res            (res),
    .exception      (exception)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Arithmetic-level model: aligned integer significands, then normalise loop
  function automatic void model(input logic [31:0] ia, input logic [31:0] ib,
                                input logic is, output logic [31:0] r,
                                output logic e, output int lat);
    logic [31:0] x, y, t;
    int          ex, ey, d, n;
    longint      mx, my, m;
    logic        sg;
    x = ia;
    y = ib;
    y[31] = ib[31] ^ is;
    if (y[30:0] > x[30:0]) begin t = x; x = y; y = t; end
    sg = x[31];
    e  = 1'b0;
    if (ia[30:23] == 8'hFF || ib[30:23] == 8'hFF) begin
      r   = sg ? 32'hFF800000 : 32'h7F800000;
      e   = 1'b1;
      lat = 2;
      return;
    end
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    d  = ex - ey;
    if (d > 25) d = 25;
    mx = longint'(x[22:0]);
    if (ex != 0) mx = mx + 8388608;
    my = longint'(y[22:0]);
    if (ey != 0) my = my + 8388608;
    my = my >> d;
    m  = (x[31] != y[31]) ? (mx - my) : (mx + my);
    n  = 0;
    while (n < 64) begin
      n++;
      if (m >= 16777216) begin
        m  = m >> 1;
        ex = ex + 1;
        if (ex == 255) e = 1'b1;
        break;
      end
      if (m == 0) begin ex = 0; sg = 1'b0; break; end
      if (m >= 8388608 || ex <= 1) begin
        if (m < 8388608) ex = 0;
        break;
      end
      m  = m << 1;
      ex = ex - 1;
    end
    if (e) r = sg ? 32'hFF800000 : 32'h7F800000;
    else   r = {sg, 8'(ex), 23'(m)};
    lat = 3 + d + n;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, got, want);
    end
  endtask

  task automatic pin(input logic [31:0] ta, input logic [31:0] tb2, input logic ts,
                     input logic [31:0] want_r, input logic want_e, input int want_l);
    logic [31:0] r;
    logic        e;
    int          l;
    model(ta, tb2, ts, r, e, l);
    chk("model_res", r, want_r);
    chk("model_exc", 32'(e), 32'(want_e));
    chk("model_lat", 32'(l), 32'(want_l));
  endtask

  // Compare process: literal pins on the model, then per-cycle output checks
  initial begin
    checks = 0;
    errors = 0;
    held_res = '0;
    held_exc = 1'b0;
    pin(32'h4383C7AE, 32'h4164F5C3, 1'b0, 32'h438AEF5C, 1'b0, 9);
    pin(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 4);
    pin(32'h3F7D70A4, 32'h3F7D70A4, 1'b1, 32'h00000000, 1'b0, 4);
    pin(32'h3F800000, 32'h3F000000, 1'b1, 32'h3F000000, 1'b0, 6);
    pin(32'h3F000000, 32'h3F800000, 1'b1, 32'hBF000000, 1'b0, 6);
    pin(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1'b1, 2);
    pin(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 4);
    pin(32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 1'b0, 27);
    pin(32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 1'b0, 29);
    forever begin
      @(negedge clk);
      if (chk_on) begin
        el       = cyc - start_cyc;
        exp_done = pending && (el == exp_lat);
        exp_busy = pending && (el < exp_lat);
        if (clear_req) begin
          held_res = '0;
          held_exc = 1'b0;
        end
        if (exp_done) begin
          held_res = exp_res;
          held_exc = exp_exc;
        end
        chk("done", 32'(done), 32'(exp_done));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("res", res, held_res);
        chk("exception", 32'(exception), 32'(held_exc));
      end
    end
  end

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb2, input logic ts);
    logic [31:0] r;
    logic        e;
    int          l;
    model(ta, tb2, ts, r, e, l);
    @(negedge clk);
    a = ta;
    b = tb2;
    add_sub_signal = ts;
    start = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    start_cyc = cyc;
    exp_res   = r;
    exp_exc   = e;
    exp_lat   = l;
    pending   = 1'b1;
    a = $urandom;
    b = $urandom;
    add_sub_signal = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (pending && (cyc - start_cyc <= exp_lat)) begin
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        $display("FAIL wait_idle: no completion within 200 cycles");
        $fatal(1);
      end
    end
  endtask

  logic [31:0] va [15];
  logic [31:0] vb [15];
  logic        vs [15];

  initial begin
    va = '{32'h4383C7AE, 32'h3F800000, 32'h3F7D70A4, 32'h3F800000, 32'h3F000000,
           32'h7F800000, 32'h00000001, 32'h7F7FFFFF, 32'h3F800000, 32'h3F800000,
           32'hBF800000, 32'h3F800001, 32'h3F800000, 32'h00800000, 32'h40490FDB};
    vb = '{32'h4164F5C3, 32'h3F800000, 32'h3F7D70A4, 32'h3F000000, 32'h3F800000,
           32'h3F800000, 32'h00000001, 32'h7F7FFFFF, 32'h33000000, 32'h00800000,
           32'hBF800000, 32'h3F800000, 32'hFFC00000, 32'h00400000, 32'hC02DF854};
    vs = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    cyc = 0;
    start_cyc = 0;
    exp_lat = 0;
    exp_res = '0;
    exp_exc = 1'b0;
    pending = 1'b0;
    clear_req = 1'b1;
    chk_on = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    add_sub_signal = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1 chk_on = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_req = 1'b0;

    for (int i = 0; i < 15; i++) begin
      run_op(va[i], vb[i], vs[i]);
      wait_idle();
    end

    // start pulsed while busy must be ignored
    run_op(32'h4383C7AE, 32'h4164F5C3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a = 32'h7F800000;
    b = 32'h3F800000;
    add_sub_signal = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    // reset during ALIGN aborts with no done pulse
    run_op(32'h4383C7AE, 32'h4164F5C3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    pending = 1'b0;
    clear_req = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_req = 1'b0;
    repeat (12) @(negedge clk);

    run_op(32'h3F800000, 32'h3F000000, 1'b1);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
